alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage consumer of the 4-bit alu_select code from the ALU control decoder.
//  Accepts one operation and two operands over a valid/ready handshake and returns result, zero and illegal flags.
//  Logic/arith ops complete in 1 cycle; SLL/SRL iterate bit-serially, 1 bit per cycle.
//  Sits between operand-select muxes and writeback/branch logic; the shifter is area-reduced.
// PARAMETERS
//  XLEN     32             operand/result width
//  SHAMT_W  $clog2(XLEN)   shift-amount width (5 for XLEN=32)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        op/operands valid
//  in_ready   out  1        unit can accept (high only in IDLE)
//  alu_select in   4        op code: SLT=0 ADD=1 SUB=2 AND=3 OR=4 XOR=5 SLL=6 SRL=7 EQ=8
//  op_a       in   XLEN     operand A (rs1)
//  op_b       in   XLEN     operand B (rs2/imm); shamt = op_b[SHAMT_W-1:0]
//  out_valid  out  1        result valid; held until out_ready
//  out_ready  in   1        downstream accepts result
//  result     out  XLEN     operation result
//  zero       out  1        result == 0
//  illegal    out  1        alu_select was 9..15
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n low): state=IDLE; in_ready=1 after release; out_valid=0, result=0, zero=0, illegal=0, busy=0.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE: in_ready=1. On in_valid&&in_ready, capture alu_select, op_a, op_b.
//   - Non-shift op: compute into result reg -> DONE; out_valid asserts the next cycle (latency 1).
//   - SLL/SRL with shamt==0: result=op_a -> DONE (latency 1).
//   - SLL/SRL with shamt>0: load acc=op_a, cnt=shamt -> SHIFT.
//  SHIFT: each cycle acc shifts 1 (SLL: left, 0-fill; SRL: right, logical 0-fill); cnt--.
//   - When cnt reaches 1 on the current shift: result=final acc -> DONE.
//   - Total latency from accept to out_valid = shamt+1 cycles (shamt=31 -> 32 cycles).
//  DONE: out_valid=1; result, zero and illegal are stable. On out_ready go to IDLE.
//   - out_valid deasserts in the cycle after the handshake.
//   - No new input is accepted in the DONE cycle (in_ready=0).
//  Arithmetic rules:
//   - ADD/SUB wrap modulo 2^XLEN; no carry or overflow output.
//   - SLT: signed compare; result={XLEN-1'b0, a<b}.
//   - EQ: result={XLEN-1'b0, a==b}. zero=1 iff a!=b (branch consumers use zero or result[0]).
//   - Illegal codes 9..15: result=0, zero=1, illegal=1, latency 1. Never hang.
//  Boundaries:
//   - in_valid while busy: ignored; in_ready=0, no capture.
//   - Operands change after capture: no effect on the result.
//   - out_ready held high continuously: back-to-back ops, 1 idle cycle between results.
//   - out_ready low: DONE is held indefinitely.
//   - Reset mid-SHIFT or mid-DONE: immediate abort to IDLE; result is discarded.
//   - No X propagation: all regs have reset values.
//   - $display only under `ifdef SIM.
// STRUCTURE
//  Shared package alu_pkg:
//   - localparams ALU_SLT..ALU_EQ (4'b0000..4'b1000), shared with the ALU control decoder.
//   - FSM state encoding.
//  Sub-module alu_serial_shifter: acc/cnt registers, load/step/done interface.
//  The single-cycle op mux stays inline in alu_exec_unit.
// TESTING
//  1. Reset mid-op: rst_n low mid-SHIFT -> out_valid=0, busy=0, in_ready=1 immediately after release.
//  2. ADD: A=32'hFFFF_FFFF, B=1 -> result=0, zero=1, out_valid 1 cycle after accept.
//     SUB: A=5, B=7 -> result=32'hFFFF_FFFE.
//  3. SLT: A=32'h8000_0000, B=1 -> result=1. EQ: A=B=32'h1234 -> result=1, zero=0.
//  4. SLL: A=1, B=31 -> result=32'h8000_0000 after exactly 32 cycles; in_ready=0 throughout.
//     SRL: A=32'h8000_0000, B=4 -> result=32'h0800_0000.
//  5. Backpressure: out_ready=0 for 10 cycles -> result stable, out_valid held.
//     in_valid pulses during SHIFT are ignored.
//  6. Illegal code 4'hC -> illegal=1, result=0, zero=1.
//     Shift with B=32'h20 (shamt=0) -> result=A, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes and execute-unit FSM encoding
//
// Shared between the ALU control decoder and alu_exec_unit.
// ALU_SLT..ALU_EQ : 4-bit alu_select codes; codes above ALU_EQ are illegal.
// ST_IDLE/ST_SHIFT/ST_DONE : alu_exec_unit state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_SLT = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_EQ  = 4'b1000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic is_shift_op(input logic [3:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// rtl/alu_serial_shifter.sv - bit-serial logical shifter, one bit per step
//
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  load         capture load_data/load_cnt/shift_left
//  shift_left   1 = SLL (left, 0-fill), 0 = SRL (right, logical)
//  load_data    initial accumulator value (operand A)
//  load_cnt     number of single-bit shifts to perform (must be > 0)
//  step         perform one shift this cycle
//  acc_next     accumulator value after the current step
//  last         the current step is the final one (acc_next is the answer)
module alu_serial_shifter #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               shift_left,
    input  logic [XLEN-1:0]    load_data,
    input  logic [SHAMT_W-1:0] load_cnt,
    input  logic               step,
    output logic [XLEN-1:0]    acc_next,
    output logic               last
);

    logic [XLEN-1:0]    acc;
    logic [SHAMT_W-1:0] cnt;
    logic               dir_left;

    assign acc_next = dir_left ? (acc << 1) : (acc >> 1);
    // cnt counts remaining shifts including the current one.
    assign last     = (cnt == SHAMT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            dir_left <= 1'b0;
        end else if (load) begin
            acc      <= load_data;
            cnt      <= load_cnt;
            dir_left <= shift_left;
        end else if (step) begin
            acc <= acc_next;
            cnt <= cnt - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with valid/ready handshake and serial shifter
//
// Ports:
//  clk, rst_n            clock, asynchronous active-low reset
//  in_valid / in_ready   operation handshake (in_ready high only in IDLE)
//  alu_select            op code (alu_pkg ALU_*), 9..15 illegal
//  op_a, op_b            operands; shift amount is op_b[SHAMT_W-1:0]
//  out_valid / out_ready result handshake; result held until accepted
//  result, zero, illegal registered outputs, stable while out_valid
//  busy                  unit is not idle
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_select,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    logic [1:0]         state;
    logic [XLEN-1:0]    alu_out;
    logic               illegal_op;
    logic               shift_op;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;
    logic               start_shift;
    logic [XLEN-1:0]    acc_next;
    logic               shift_last;

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);

    assign shamt       = op_b[SHAMT_W-1:0];
    assign shift_op    = is_shift_op(alu_select);
    assign illegal_op  = (alu_select > ALU_EQ);
    assign accept      = in_valid && in_ready;
    // Zero-length shifts bypass the serial path and finish like a 1-cycle op.
    assign start_shift = accept && shift_op && (shamt != '0);

    // Single-cycle result mux; shift codes here only serve the shamt==0 case.
    always_comb begin
        alu_out = '0;
        case (alu_select)
            ALU_SLT: alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_ADD: alu_out = op_a + op_b;
            ALU_SUB: alu_out = op_a - op_b;
            ALU_AND: alu_out = op_a & op_b;
            ALU_OR:  alu_out = op_a | op_b;
            ALU_XOR: alu_out = op_a ^ op_b;
            ALU_SLL: alu_out = op_a;
            ALU_SRL: alu_out = op_a;
            ALU_EQ:  alu_out = {{(XLEN-1){1'b0}}, (op_a == op_b)};
            default: alu_out = '0;
        endcase
    end

    alu_serial_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (start_shift),
        .shift_left (alu_select == ALU_SLL),
        .load_data  (op_a),
        .load_cnt   (shamt),
        .step       (state == ST_SHIFT),
        .acc_next   (acc_next),
        .last       (shift_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        illegal <= illegal_op;
                        if (start_shift) begin
                            state <= ST_SHIFT;
                        end else begin
                            result <= alu_out;
                            zero   <= (alu_out == '0);
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (shift_last) begin
                        result <= acc_next;
                        zero   <= (acc_next == '0);
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_select = 4'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_select (alu_select),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal    (illegal),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (s)
            4'd0: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd1: return a + b;
            4'd2: return a - b;
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return a ^ b;
            4'd6: return a << sh;
            4'd7: return a >> sh;
            4'd8: return (a == b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Drive one op, wait for its result and compare it against the scoreboard.
    // pulse: toggle in_valid with junk while the unit is shifting.
    // hold : cycles to keep out_ready low once the result is presented.
    task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input bit pulse, input int hold);
        exp_t e;
        exp_t got;
        int   cyc;
        logic [4:0] sh;
        sh    = b[4:0];
        e.res = model(sel, a, b);
        e.z   = (e.res == 32'd0);
        e.ill = (sel > 4'd8);
        e.lat = ((sel == 4'd6 || sel == 4'd7) && sh != 5'd0) ? int'(sh) + 1 : 1;
        @(negedge clk);
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        out_ready  = (hold == 0);
        in_valid   = 1'b1;
        alu_select = sel;
        op_a       = a;
        op_b       = b;
        sb.push_back(e);
        @(negedge clk);
        in_valid   = 1'b0;
        alu_select = 4'($urandom);
        op_a       = $urandom;
        op_b       = $urandom;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            check("in_ready_busy", {63'd0, in_ready}, 64'd0);
            if (pulse) begin
                in_valid   = 1'b1;
                alu_select = ALU_ADD;
                op_a       = $urandom;
                op_b       = $urandom;
            end
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
        end
        check("out_valid", {63'd0, out_valid}, 64'd1);
        got = sb.pop_front();
        check("latency", 64'(cyc), 64'(got.lat));
        check("result", {32'd0, result}, {32'd0, got.res});
        check("zero", {63'd0, zero}, {63'd0, got.z});
        check("illegal", {63'd0, illegal}, {63'd0, got.ill});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_result", {32'd0, result}, {32'd0, got.res});
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", {63'd0, out_valid}, 64'd0);
        check("idle_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  s;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_zero", {63'd0, zero}, 64'd0);
        check("rst_illegal", {63'd0, illegal}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        run_op(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        run_op(ALU_SUB, 32'd5, 32'd7, 1'b0, 0);
        run_op(ALU_SLT, 32'h8000_0000, 32'd1, 1'b0, 0);
        run_op(ALU_SLT, 32'd1, 32'h8000_0000, 1'b0, 0);
        run_op(ALU_EQ, 32'h1234, 32'h1234, 1'b0, 0);
        run_op(ALU_EQ, 32'h1234, 32'h1235, 1'b0, 0);
        run_op(ALU_SLL, 32'd1, 32'd31, 1'b0, 0);
        run_op(ALU_SRL, 32'h8000_0000, 32'd4, 1'b0, 0);
        run_op(4'hC, 32'hDEAD_BEEF, 32'h1, 1'b0, 0);
        run_op(ALU_SLL, 32'hA5A5_0001, 32'h20, 1'b0, 0);
        run_op(ALU_SRL, 32'hF0F0_F0F0, 32'd9, 1'b1, 10);
        run_op(ALU_XOR, 32'h0F0F_0F0F, 32'hFFFF_0000, 1'b0, 10);

        for (int i = 0; i < 24; i++) begin
            s = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if (s == ALU_SLL || s == ALU_SRL) b = 32'($urandom_range(0, 12));
            run_op(s, a, b, i[0], i % 3);
        end

        // Reset in the middle of a long shift must abort with nothing presented.
        @(negedge clk);
        in_valid   = 1'b1;
        alu_select = ALU_SLL;
        op_a       = 32'h3;
        op_b       = 32'd20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midshift_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_result", {32'd0, result}, 64'd0);
        repeat (25) begin
            @(negedge clk);
            check("abort_quiet", {63'd0, out_valid}, 64'd0);
        end

        run_op(ALU_OR, 32'h0000_00F0, 32'h0000_000F, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
